// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Multi-cycle data-memory sequencer for the MEM/WB stage. Accepts one decoded
// load/store at a time, runs a req/ack transaction on the data-memory port and
// returns aligned, extended load data. Misaligned accesses and bus timeouts are
// reported as one-cycle error pulses.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   mem_valid, dmem_sel   : op present this cycle; 1 = store, 0 = load
//   w_sel, r_sel          : store size / load type from the decoder
//   addr, wdata           : byte address and store data (rs2)
//   flush                 : squash the current instruction
//   stall                 : hold the pipeline
//   rdata_out, rdata_valid: extended load result and its one-cycle strobe
//   misalign_err          : one-cycle pulse, misaligned access rejected
//   timeout_err           : one-cycle pulse, no mem_ack within TIMEOUT_CYCLES
//   mem_req/we/be/addr/wdata, mem_ack, mem_rdata : data-memory bus
module dmem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              dmem_sel,
  input  logic [1:0]        w_sel,
  input  logic [2:0]        r_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  output logic              stall,
  output logic [31:0]       rdata_out,
  output logic              rdata_valid,
  output logic              misalign_err,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               flush_q, flush_d;
  logic [2:0]         rtype_q, rtype_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        rdata_out_q, rdata_out_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               misalign_err_q, misalign_err_d;
  logic               timeout_err_q, timeout_err_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  // Decode of the incoming op
  logic        is_store, is_load, valid_op, is_half, is_word, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    is_store = dmem_sel && (w_sel != 2'b11);
    is_load  = !dmem_sel && (r_sel == 3'b000 || r_sel == 3'b010 || r_sel == 3'b011 ||
                             r_sel == 3'b100 || r_sel == 3'b101);
    valid_op = mem_valid && (is_store || is_load);
    is_half  = dmem_sel ? (w_sel == 2'b01) : (r_sel == 3'b010 || r_sel == 3'b101);
    is_word  = dmem_sel ? (w_sel == 2'b10) : (r_sel == 3'b011);
    misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

    be_new    = 4'b1111;
    wdata_new = wdata;
    if (is_store) begin
      unique case (w_sel)
        2'b00: begin
          be_new    = 4'b0001 << addr[1:0];
          wdata_new = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_new    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{wdata[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = wdata;
        end
      endcase
    end
  end

  // Lane select and extension of the returned word, using the latched
  // load type and byte offset of the transaction in flight.
  always_comb begin
    unique case (off_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (rtype_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b010:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush_d        = flush_q;
    rtype_d        = rtype_q;
    off_d          = off_q;
    rdata_out_d    = rdata_out_q;
    rdata_valid_d  = 1'b0;
    misalign_err_d = 1'b0;
    timeout_err_d  = 1'b0;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_be_d       = mem_be_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (valid_op && !flush) begin
          if (misaligned) begin
            misalign_err_d = 1'b1;
            state_d        = ERR;
          end else begin
            rtype_d     = r_sel;
            off_d       = addr[1:0];
            mem_we_d    = is_store;
            mem_be_d    = be_new;
            mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = wdata_new;
            mem_req_d   = 1'b1;
            cnt_d       = 8'd0;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          // A flush arriving in the ack cycle squashes the load as well.
          flush_d   = flush_q || flush;
          if (!mem_we_q && !flush_q && !flush) begin
            rdata_out_d   = load_ext;
            rdata_valid_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          if (flush) flush_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TO_LIMIT) begin
            mem_req_d     = 1'b0;
            timeout_err_d = 1'b1;
            flush_d       = 1'b0;
            state_d       = ERR;
          end
        end
      end
      RESP: begin
        flush_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      flush_q        <= 1'b0;
      rtype_q        <= 3'b111;
      off_q          <= 2'b00;
      rdata_out_q    <= 32'd0;
      rdata_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_be_q       <= 4'b0000;
      mem_addr_q     <= '0;
      mem_wdata_q    <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flush_q        <= flush_d;
      rtype_q        <= rtype_d;
      off_q          <= off_d;
      rdata_out_q    <= rdata_out_d;
      rdata_valid_q  <= rdata_valid_d;
      misalign_err_q <= misalign_err_d;
      timeout_err_q  <= timeout_err_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_be_q       <= mem_be_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  // Stall is combinational in IDLE so the accepting cycle is already held.
  assign stall        = (state_q == ISSUE) || (state_q == IDLE && valid_op && !flush);
  assign rdata_out    = rdata_out_q;
  assign rdata_valid  = rdata_valid_q;
  assign misalign_err = misalign_err_q;
  assign timeout_err  = timeout_err_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_be       = mem_be_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, dmem_sel, flush, mem_ack;
  logic [1:0]  w_sel;
  logic [2:0]  r_sel;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, rdata_valid, misalign_err, timeout_err, mem_req, mem_we;
  logic [31:0] rdata_out, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .dmem_sel(dmem_sel),
    .w_sel(w_sel), .r_sel(r_sel), .addr(addr), .wdata(wdata), .flush(flush),
    .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .misalign_err(misalign_err), .timeout_err(timeout_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mem_valid = 1'b0; dmem_sel = 1'b0; w_sel = 2'b11; r_sel = 3'b111;
    flush = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic present(input logic st, input logic [1:0] ws, input logic [2:0] rs,
                         input logic [31:0] a, input logic [31:0] wd);
    mem_valid = 1'b1; dmem_sel = st; w_sel = ws; r_sel = rs; addr = a; wdata = wd;
  endtask

  // Accept an op, ack it in the first ISSUE cycle, return in the RESP cycle.
  task automatic access(input string tag, input logic st, input logic [1:0] ws,
                        input logic [2:0] rs, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    present(st, ws, rs, a, wd);
    #1;
    check({tag, "_accept_stall"}, 32'(stall), 32'd1);
    check({tag, "_accept_noreq"}, 32'(mem_req), 32'd0);
    step;
    idle_inputs();
    mem_ack = 1'b1; mem_rdata = rd;
    #1;
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_issue_stall"}, 32'(stall), 32'd1);
    check({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
    check({tag, "_we"}, 32'(mem_we), 32'(st));
    check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
    if (st) check({tag, "_wdata"}, mem_wdata, exp_wd);
    step;
    mem_ack = 1'b0;
    #1;
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    check({tag, "_resp_noreq"}, 32'(mem_req), 32'd0);
  endtask

  int req_cycles, to_pulses, to_pos, stall_at_err;

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; mem_rdata = '0;
    idle_inputs();
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_flags", {28'd0, rdata_valid, misalign_err, timeout_err, mem_we}, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step;

    // Loads: extension and lane selection
    access("lb", 1'b0, 2'b11, 3'b000, 32'h1003, 32'd0, 32'h80FF_1234, 4'b1111, 32'd0);
    check("lb_valid", 32'(rdata_valid), 32'd1);
    check("lb_data", rdata_out, 32'hFFFF_FF80);
    step;
    check("lb_valid_pulse", 32'(rdata_valid), 32'd0);
    check("lb_data_hold", rdata_out, 32'hFFFF_FF80);

    access("lhu", 1'b0, 2'b11, 3'b101, 32'h2002, 32'd0, 32'hBEEF_0000, 4'b1111, 32'd0);
    check("lhu_data", rdata_out, 32'h0000_BEEF);
    step;
    access("lh", 1'b0, 2'b11, 3'b010, 32'h2002, 32'd0, 32'hBEEF_0000, 4'b1111, 32'd0);
    check("lh_data", rdata_out, 32'hFFFF_BEEF);
    step;
    access("lbu", 1'b0, 2'b11, 3'b100, 32'h1001, 32'd0, 32'h0000_9A00, 4'b1111, 32'd0);
    check("lbu_data", rdata_out, 32'h0000_009A);
    step;

    // Stores: byte enables and lane replication; rdata_out untouched
    access("sb", 1'b1, 2'b00, 3'b111, 32'h11, 32'h0000_00AB, 32'd0, 4'b0010, 32'hABAB_ABAB);
    check("sb_novalid", 32'(rdata_valid), 32'd0);
    check("sb_data_hold", rdata_out, 32'h0000_009A);
    step;
    access("sh", 1'b1, 2'b01, 3'b111, 32'h12, 32'h0000_1234, 32'd0, 4'b1100, 32'h1234_1234);
    step;
    access("sw", 1'b1, 2'b10, 3'b111, 32'h20, 32'hDEAD_BEEF, 32'd0, 4'b1111, 32'hDEAD_BEEF);
    step;

    // Misaligned LW
    present(1'b0, 2'b11, 3'b011, 32'h6, 32'd0);
    #1 check("mis_accept_stall", 32'(stall), 32'd1);
    step;
    idle_inputs();
    #1;
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_noreq", 32'(mem_req), 32'd0);
    check("mis_stall", 32'(stall), 32'd0);
    check("mis_no_to", 32'(timeout_err), 32'd0);
    step;
    check("mis_err_pulse", 32'(misalign_err), 32'd0);
    check("mis_noreq2", 32'(mem_req), 32'd0);

    // Timeout with TIMEOUT_CYCLES=4
    present(1'b0, 2'b11, 3'b011, 32'h40, 32'd0);
    step;
    idle_inputs();
    req_cycles = 0; to_pulses = 0; to_pos = -1; stall_at_err = -1;
    for (int k = 0; k < 10; k++) begin
      if (mem_req) req_cycles++;
      if (timeout_err) begin
        to_pulses++; to_pos = k; stall_at_err = int'(stall);
      end
      step;
    end
    check("to_req_cycles", 32'(req_cycles), 32'd4);
    check("to_pulses", 32'(to_pulses), 32'd1);
    check("to_pos", 32'(to_pos), 32'd4);
    check("to_err_stall", 32'(stall_at_err), 32'd0);

    // Flush during ISSUE of an LW: stall until ack, no rdata_valid
    present(1'b0, 2'b11, 3'b011, 32'h44, 32'd0);
    step;
    idle_inputs();
    flush = 1'b1;
    #1 check("fl_c1_stall", 32'(stall), 32'd1);
    step;
    flush = 1'b0;
    #1 check("fl_c2_stall", 32'(stall), 32'd1);
    check("fl_c2_req", 32'(mem_req), 32'd1);
    step;
    check("fl_c3_stall", 32'(stall), 32'd1);
    step;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1 check("fl_c4_stall", 32'(stall), 32'd1);
    step;
    mem_ack = 1'b0;
    #1;
    check("fl_resp_stall", 32'(stall), 32'd0);
    check("fl_novalid", 32'(rdata_valid), 32'd0);
    check("fl_data_hold", rdata_out, 32'h0000_009A);
    step;

    // mem_ack outside ISSUE is ignored
    mem_ack = 1'b1;
    step;
    check("ack_idle_req", 32'(mem_req), 32'd0);
    check("ack_idle_valid", 32'(rdata_valid), 32'd0);
    mem_ack = 1'b0;
    step;

    // Back-to-back SW then LW; LW accepted the cycle after RESP
    present(1'b1, 2'b10, 3'b111, 32'h50, 32'h1122_3344);
    step;
    mem_ack = 1'b1;
    #1 check("b2b_sw_req", 32'(mem_req), 32'd1);
    step;
    mem_ack = 1'b0;
    present(1'b0, 2'b11, 3'b011, 32'h54, 32'd0);
    #1 check("b2b_resp_stall", 32'(stall), 32'd0);
    step;
    check("b2b_accept_stall", 32'(stall), 32'd1);
    check("b2b_accept_noreq", 32'(mem_req), 32'd0);
    step;
    idle_inputs();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    check("b2b_lw_req", 32'(mem_req), 32'd1);
    check("b2b_lw_addr", mem_addr, 32'h54);
    check("b2b_lw_we", 32'(mem_we), 32'd0);
    step;
    mem_ack = 1'b0;
    #1;
    check("b2b_lw_valid", 32'(rdata_valid), 32'd1);
    check("b2b_lw_data", rdata_out, 32'hCAFE_F00D);
    step;

    // Reset mid-ISSUE
    present(1'b0, 2'b11, 3'b011, 32'h48, 32'd0);
    step;
    idle_inputs();
    #1 check("rmid_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid_req", 32'(mem_req), 32'd0);
    check("rmid_stall", 32'(stall), 32'd0);
    check("rmid_rdata", rdata_out, 32'd0);
    #2 rst_n = 1'b1;
    step;
    check("rmid_idle_req", 32'(mem_req), 32'd0);
    check("rmid_idle_stall", 32'(stall), 32'd0);
    access("rmid_lw", 1'b0, 2'b11, 3'b011, 32'h4C, 32'd0, 32'h0000_0001, 4'b1111, 32'd0);
    check("rmid_lw_data", rdata_out, 32'h0000_0001);
    step;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Multi-cycle data-memory sequencer for the pipelined RISC-V core's MEM/WB stage. It takes the decoded memory controls (dmem_sel, w_sel, r_sel) plus address and store data. It runs a req/ack transaction on the data-memory port, generating byte enables and replicated store lanes, and returns aligned, sign- or zero-extended load data. It stalls the pipeline until the access completes, and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, cycles in ISSUE without mem_ack before a timeout error; range 1..255, 8-bit counter.
ADDR_W, 32, byte-address width.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_valid  input  1  pipeline presents a memory op this cycle
dmem_sel  input  1  1 = store, 0 = load
w_sel  input  2  store size: 00 byte, 01 half, 10 word, 11 none
r_sel  input  3  load type: 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 111 none; others reserved, treated as none
addr  input  ADDR_W  byte address
wdata  input  32  store data (rs2)
flush  input  1  squash the current instruction
stall  output  1  hold pipeline
rdata_out  output  32  extended load result
rdata_valid  output  1  one-cycle pulse, rdata_out valid
misalign_err  output  1  one-cycle pulse
timeout_err  output  1  one-cycle pulse
mem_req  output  1  bus request
mem_we  output  1  bus write
mem_be  output  4  byte enables
mem_addr  output  ADDR_W  word-aligned address, addr[1:0] forced to 00
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  bus completion
mem_rdata  input  32  bus read word

Behaviour:
- Reset: async on rst_n low. State IDLE, timeout counter 0, flush flag 0. All outputs 0, including rdata_out, mem_addr and mem_wdata.
- Valid op: mem_valid=1 and either (dmem_sel=1, w_sel!=11) or (dmem_sel=0, r_sel in {000,010,011,100,101}). Anything else is a no-op: stall stays 0 and there is no bus activity.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=00.
- States:
  - IDLE:
    - Valid op, misaligned, flush=0: go to ERR.
    - Valid op, aligned, flush=0: latch addr, size, load type, mem_we, mem_be and mem_wdata; clear counter; go to ISSUE.
    - flush=1: no access.
    - stall is combinationally 1 while in IDLE with a valid, unflushed op.
  - ISSUE:
    - mem_req=1; bus outputs held stable, with no change until ack. stall=1.
    - mem_ack=1: capture mem_rdata and go to RESP.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES, drop mem_req and go to ERR with timeout cause.
  - RESP (1 cycle):
    - mem_req=0, stall=0.
    - Load and flush flag clear: rdata_valid=1 and rdata_out is updated.
    - Clear flush flag; go to IDLE.
  - ERR (1 cycle): stall=0; misalign_err or timeout_err=1 per cause; go to IDLE.
- Latency: aligned op with ack in the first ISSUE cycle gives accept at cycle 0, req at cycle 1, RESP at cycle 2, so stall is high for 2 cycles.
- Store lanes:
  - SB: mem_wdata = {4{wdata[7:0]}}, mem_be = 0001 << addr[1:0].
  - SH: mem_wdata = {2{wdata[15:0]}}, mem_be = 0011 << (2*addr[1]).
  - SW: mem_wdata = wdata, mem_be = 1111.
- Loads: mem_be=1111, mem_we=0.
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - rdata_out holds its value until the next RESP load.
- Flush during ISSUE: the bus transaction is never abandoned. Set the flush flag, keep stall=1 until ack, complete any store, and suppress rdata_valid for loads.
- mem_ack outside ISSUE is ignored.
- rst_n low mid-transaction: immediate return to IDLE and mem_req=0; the bus side must tolerate the abort.

Test Plan:
- LB addr=0x1003, mem_rdata=0x80FF_1234, ack on the first ISSUE cycle -> mem_addr=0x1000, be=1111, stall high for 2 cycles, rdata_out=0xFFFF_FF80, rdata_valid pulses once.
- LHU addr=0x2002, mem_rdata=0xBEEF_0000 -> rdata_out=0x0000_BEEF. Same data as LH -> 0xFFFF_BEEF.
- SB addr=0x11, wdata=0xAB -> mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB, mem_addr=0x10. SH addr=0x12 -> be=1100. SW -> be=1111.
- LW addr=0x6 -> misalign_err pulses 1 cycle, mem_req never asserts, stall=0 in the ERR cycle.
- Ack withheld, TIMEOUT_CYCLES=4 -> mem_req high for exactly 4 cycles, then timeout_err pulses and the FSM returns to IDLE.
- flush asserted during ISSUE of an LW, ack after 3 cycles -> stall held until ack, rdata_valid stays 0.
- rst_n low mid-ISSUE -> mem_req=0 immediately, IDLE after release.
- Back-to-back SW then LW -> the second op is accepted the cycle after RESP.
